udma_hyper_txseq: RTL and testbench

UDMA_HYPER_TXSEQ -- requirements
Module: udma_hyper_txseq

---
 rtl/udma_hyper_txseq_if.sv | 33 +++
 rtl/udma_hyper_txseq.sv | 182 ++++++++++++++++++
 tb/tb_udma_hyper_txseq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/udma_hyper_txseq_if.sv
// Handshake and data bundle between the HyperBus TX write sequencer and its
// controller, PHY and TX buffer; the slave modport is the sequencer's side.
interface udma_hyper_txseq_if #(
  parameter int TRANS_SIZE = 16
) ();
  logic                  start_i;
  logic                  abort_i;
  logic [TRANS_SIZE-1:0] len_i;
  logic [4:0]            latency_i;
  logic                  reg_wr_i;
  logic                  wide_i;
  logic [47:0]           ca_i;
  logic                  phy_ready_i;
  logic                  ca_valid_o;
  logic [15:0]           ca_data_o;
  logic                  buf_dst_ready_o;
  logic                  buf_valid_i;
  logic [TRANS_SIZE-1:0] remained_o;
  logic                  busy_o;
  logic                  done_o;

  modport slave (
    input  start_i, abort_i, len_i, latency_i, reg_wr_i, wide_i, ca_i,
           phy_ready_i, buf_valid_i,
    output ca_valid_o, ca_data_o, buf_dst_ready_o, remained_o, busy_o, done_o
  );

  modport master (
    output start_i, abort_i, len_i, latency_i, reg_wr_i, wide_i, ca_i,
           phy_ready_i, buf_valid_i,
    input  ca_valid_o, ca_data_o, buf_dst_ready_o, remained_o, busy_o, done_o
  );
endinterface

// File: rtl/udma_hyper_txseq.sv
// HyperBus TX write sequencer: sends the 3-word command-address, waits the
// latency, then meters data beats until the byte count is exhausted.
module udma_hyper_txseq #(
  parameter int TRANS_SIZE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  udma_hyper_txseq_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CA   = 3'd1,
    ST_LAT  = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [TRANS_SIZE-1:0] BYTES_NARROW = TRANS_SIZE'(3'd2);
  localparam logic [TRANS_SIZE-1:0] BYTES_WIDE   = TRANS_SIZE'(3'd4);

  state_e                state_r, state_s;
  logic [1:0]            ca_idx_r, ca_idx_s;
  logic [4:0]            lat_cnt_r, lat_cnt_s;
  logic [4:0]            lat_r, lat_s;
  logic                  reg_wr_r, reg_wr_s;
  logic                  wide_r, wide_s;
  logic [47:0]           ca_r, ca_s;
  logic [TRANS_SIZE-1:0] remained_r, remained_s;
  logic [TRANS_SIZE-1:0] beat_bytes_s;
  logic [15:0]           ca_word_s;

  logic                  ca_valid_r;
  logic [15:0]           ca_data_r;
  logic                  buf_dst_ready_r;
  logic                  busy_r;
  logic                  done_r;

  // Next-state and next-configuration decode
  always_comb begin
    state_s      = state_r;
    ca_idx_s     = ca_idx_r;
    lat_cnt_s    = lat_cnt_r;
    lat_s        = lat_r;
    reg_wr_s     = reg_wr_r;
    wide_s       = wide_r;
    ca_s         = ca_r;
    remained_s   = remained_r;
    beat_bytes_s = wide_r ? BYTES_WIDE : BYTES_NARROW;

    if (bus.abort_i) begin
      state_s    = ST_IDLE;
      ca_idx_s   = 2'd0;
      lat_cnt_s  = 5'd0;
      remained_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start_i) begin
            lat_s      = bus.latency_i;
            reg_wr_s   = bus.reg_wr_i;
            wide_s     = bus.wide_i;
            ca_s       = bus.ca_i;
            ca_idx_s   = 2'd0;
            lat_cnt_s  = 5'd0;
            remained_s = bus.reg_wr_i ? BYTES_NARROW : bus.len_i;
            state_s    = ST_CA;
          end else begin
            remained_s = '0;
          end
        end
        ST_CA: begin
          if (bus.phy_ready_i) begin
            if (ca_idx_r == 2'd2) begin
              ca_idx_s  = 2'd0;
              lat_cnt_s = 5'd0;
              // remained already holds 2 for register writes, len otherwise
              if (reg_wr_r) begin
                state_s = ST_DATA;
              end else if (remained_r == '0) begin
                state_s = ST_DONE;
              end else if (lat_r == 5'd0) begin
                state_s = ST_DATA;
              end else begin
                state_s = ST_LAT;
              end
            end else begin
              ca_idx_s = ca_idx_r + 2'd1;
            end
          end else begin
            ca_idx_s = ca_idx_r;
          end
        end
        ST_LAT: begin
          if (lat_cnt_r == (lat_r - 5'd1)) begin
            lat_cnt_s = 5'd0;
            state_s   = ST_DATA;
          end else begin
            lat_cnt_s = lat_cnt_r + 5'd1;
          end
        end
        ST_DATA: begin
          if (remained_r == '0) begin
            state_s = ST_DONE;
          end else if (bus.buf_valid_i && bus.phy_ready_i) begin
            // a short final beat saturates the count and ends the burst
            if (remained_r <= beat_bytes_s) begin
              remained_s = '0;
              state_s    = ST_DONE;
            end else begin
              remained_s = remained_r - beat_bytes_s;
            end
          end else begin
            remained_s = remained_r;
          end
        end
        ST_DONE: begin
          remained_s = '0;
          state_s    = ST_IDLE;
        end
        default: begin
          remained_s = '0;
          ca_idx_s   = 2'd0;
          lat_cnt_s  = 5'd0;
          state_s    = ST_IDLE;
        end
      endcase
    end
  end

  // Select the CA half-word that will be on the bus after the next edge
  always_comb begin
    ca_word_s = 16'd0;
    case (ca_idx_s)
      2'd0:    ca_word_s = ca_s[47:32];
      2'd1:    ca_word_s = ca_s[31:16];
      2'd2:    ca_word_s = ca_s[15:0];
      default: ca_word_s = 16'd0;
    endcase
  end

  // State, configuration and registered output update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r         <= ST_IDLE;
      ca_idx_r        <= 2'd0;
      lat_cnt_r       <= 5'd0;
      lat_r           <= 5'd0;
      reg_wr_r        <= 1'b0;
      wide_r          <= 1'b0;
      ca_r            <= 48'd0;
      remained_r      <= '0;
      ca_valid_r      <= 1'b0;
      ca_data_r       <= 16'd0;
      buf_dst_ready_r <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      ca_idx_r        <= ca_idx_s;
      lat_cnt_r       <= lat_cnt_s;
      lat_r           <= lat_s;
      reg_wr_r        <= reg_wr_s;
      wide_r          <= wide_s;
      ca_r            <= ca_s;
      remained_r      <= remained_s;
      ca_valid_r      <= (state_s == ST_CA);
      ca_data_r       <= (state_s == ST_CA) ? ca_word_s : 16'd0;
      buf_dst_ready_r <= (state_s == ST_DATA);
      busy_r          <= (state_s != ST_IDLE);
      done_r          <= (state_s == ST_DONE);
    end
  end

  assign bus.ca_valid_o      = ca_valid_r;
  assign bus.ca_data_o       = ca_data_r;
  assign bus.buf_dst_ready_o = buf_dst_ready_r;
  assign bus.remained_o      = remained_r;
  assign bus.busy_o          = busy_r;
  assign bus.done_o          = done_r;

endmodule

// File: tb/tb_udma_hyper_txseq.sv
// Directed bench for udma_hyper_txseq: hand-computed CA words, latency,
// beat counts, abort and reset behaviour.
module tb_udma_hyper_txseq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  udma_hyper_txseq_if #(.TRANS_SIZE(16)) bus ();

  udma_hyper_txseq #(.TRANS_SIZE(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic cv, input logic [15:0] cd,
                         input logic bdr, input logic [15:0] rem,
                         input logic busy, input logic done);
    check({tag, ".ca_valid"},  64'(bus.ca_valid_o),      64'(cv));
    check({tag, ".ca_data"},   64'(bus.ca_data_o),       64'(cd));
    check({tag, ".buf_rdy"},   64'(bus.buf_dst_ready_o), 64'(bdr));
    check({tag, ".remained"},  64'(bus.remained_o),      64'(rem));
    check({tag, ".busy"},      64'(bus.busy_o),          64'(busy));
    check({tag, ".done"},      64'(bus.done_o),          64'(done));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] len, input logic [4:0] lat, input logic rw,
                        input logic wide, input logic [47:0] ca);
    bus.len_i     = len;
    bus.latency_i = lat;
    bus.reg_wr_i  = rw;
    bus.wide_i    = wide;
    bus.ca_i      = ca;
    bus.start_i   = 1'b1;
    step();
    bus.start_i   = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.start_i     = 1'b0;
    bus.abort_i     = 1'b0;
    bus.len_i       = 16'd0;
    bus.latency_i   = 5'd0;
    bus.reg_wr_i    = 1'b0;
    bus.wide_i      = 1'b0;
    bus.ca_i        = 48'd0;
    bus.phy_ready_i = 1'b1;
    bus.buf_valid_i = 1'b1;
    #12;
    chk_out("reset", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("idle0", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0);

    // len 8, narrow, latency 3
    launch(16'd8, 5'd3, 1'b0, 1'b0, 48'h1234_5678_9abc);
    chk_out("t1.ca0", 1'b1, 16'h1234, 1'b0, 16'd8, 1'b1, 1'b0); step();
    chk_out("t1.ca1", 1'b1, 16'h5678, 1'b0, 16'd8, 1'b1, 1'b0); step();
    chk_out("t1.ca2", 1'b1, 16'h9abc, 1'b0, 16'd8, 1'b1, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("t1.lat%0d", i), 1'b0, 16'h0000, 1'b0, 16'd8, 1'b1, 1'b0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("t1.data%0d", i), 1'b0, 16'h0000, 1'b1, 16'(8 - 2 * i), 1'b1, 1'b0);
      step();
    end
    chk_out("t1.done", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b1); step();
    chk_out("t1.idle", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0);

    // register write ignores latency and length
    launch(16'd100, 5'd7, 1'b1, 1'b0, 48'h0a0b_0c0d_0e0f);
    chk_out("t2.ca0", 1'b1, 16'h0a0b, 1'b0, 16'd2, 1'b1, 1'b0); step();
    chk_out("t2.ca1", 1'b1, 16'h0c0d, 1'b0, 16'd2, 1'b1, 1'b0); step();
    chk_out("t2.ca2", 1'b1, 16'h0e0f, 1'b0, 16'd2, 1'b1, 1'b0); step();
    chk_out("t2.data", 1'b0, 16'h0000, 1'b1, 16'd2, 1'b1, 1'b0); step();
    chk_out("t2.done", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b1); step();
    chk_out("t2.idle", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0);

    // len 5 wide, phy_ready toggling
    launch(16'd5, 5'd0, 1'b0, 1'b1, 48'haaaa_bbbb_cccc);
    chk_out("t3.ca0", 1'b1, 16'haaaa, 1'b0, 16'd5, 1'b1, 1'b0);
    bus.phy_ready_i = 1'b0; step();
    chk_out("t3.ca0h", 1'b1, 16'haaaa, 1'b0, 16'd5, 1'b1, 1'b0);
    bus.phy_ready_i = 1'b1; step();
    chk_out("t3.ca1", 1'b1, 16'hbbbb, 1'b0, 16'd5, 1'b1, 1'b0);
    bus.phy_ready_i = 1'b0; step();
    chk_out("t3.ca1h", 1'b1, 16'hbbbb, 1'b0, 16'd5, 1'b1, 1'b0);
    bus.phy_ready_i = 1'b1; step();
    chk_out("t3.ca2", 1'b1, 16'hcccc, 1'b0, 16'd5, 1'b1, 1'b0); step();
    chk_out("t3.d0", 1'b0, 16'h0000, 1'b1, 16'd5, 1'b1, 1'b0);
    bus.phy_ready_i = 1'b0; step();
    chk_out("t3.d0h", 1'b0, 16'h0000, 1'b1, 16'd5, 1'b1, 1'b0);
    bus.phy_ready_i = 1'b1; step();
    chk_out("t3.d1", 1'b0, 16'h0000, 1'b1, 16'd1, 1'b1, 1'b0);
    bus.phy_ready_i = 1'b0; step();
    chk_out("t3.d1h", 1'b0, 16'h0000, 1'b1, 16'd1, 1'b1, 1'b0);
    bus.phy_ready_i = 1'b1; step();
    chk_out("t3.done", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b1); step();
    chk_out("t3.idle", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0);

    // zero length goes straight from CA to DONE
    launch(16'd0, 5'd2, 1'b0, 1'b0, 48'h1111_2222_3333);
    chk_out("t4.ca0", 1'b1, 16'h1111, 1'b0, 16'd0, 1'b1, 1'b0); step();
    chk_out("t4.ca1", 1'b1, 16'h2222, 1'b0, 16'd0, 1'b1, 1'b0); step();
    chk_out("t4.ca2", 1'b1, 16'h3333, 1'b0, 16'd0, 1'b1, 1'b0); step();
    chk_out("t4.done", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b1); step();
    chk_out("t4.idle", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0);

    // abort in LAT and in DATA, with a competing start
    launch(16'd8, 5'd4, 1'b0, 1'b0, 48'h4444_5555_6666);
    step(); step(); step();
    chk_out("t5.lat", 1'b0, 16'h0000, 1'b0, 16'd8, 1'b1, 1'b0);
    bus.abort_i = 1'b1; bus.start_i = 1'b1; step();
    bus.abort_i = 1'b0; bus.start_i = 1'b0;
    chk_out("t5.ab1", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0); step();
    chk_out("t5.ab1i", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0);
    launch(16'd8, 5'd0, 1'b0, 1'b0, 48'h7777_8888_9999);
    step(); step(); step();
    chk_out("t5.d0", 1'b0, 16'h0000, 1'b1, 16'd8, 1'b1, 1'b0); step();
    chk_out("t5.d1", 1'b0, 16'h0000, 1'b1, 16'd6, 1'b1, 1'b0);
    bus.abort_i = 1'b1; bus.start_i = 1'b1; step();
    bus.abort_i = 1'b0; bus.start_i = 1'b0;
    chk_out("t5.ab2", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0); step();
    chk_out("t5.ab2i", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0);

    // reset in DATA, then a fresh transaction
    bus.buf_valid_i = 1'b0;
    launch(16'd6, 5'd0, 1'b0, 1'b0, 48'h0102_0304_0506);
    step(); step(); step();
    chk_out("t6.data", 1'b0, 16'h0000, 1'b1, 16'd6, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("t6.rst", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
    bus.buf_valid_i = 1'b1;
    launch(16'd4, 5'd1, 1'b0, 1'b0, 48'hdead_beef_cafe);
    chk_out("t6.ca0", 1'b1, 16'hdead, 1'b0, 16'd4, 1'b1, 1'b0); step();
    chk_out("t6.ca1", 1'b1, 16'hbeef, 1'b0, 16'd4, 1'b1, 1'b0); step();
    chk_out("t6.ca2", 1'b1, 16'hcafe, 1'b0, 16'd4, 1'b1, 1'b0); step();
    chk_out("t6.lat", 1'b0, 16'h0000, 1'b0, 16'd4, 1'b1, 1'b0); step();
    chk_out("t6.d0", 1'b0, 16'h0000, 1'b1, 16'd4, 1'b1, 1'b0); step();
    chk_out("t6.d1", 1'b0, 16'h0000, 1'b1, 16'd2, 1'b1, 1'b0); step();
    chk_out("t6.done", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b1); step();
    chk_out("t6.idle", 1'b0, 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
